memcache_key_packer: RTL and testbench

Byte-to-block packer in front of the Jenkins lookup3 hash pipeline. It takes the memcache key as a byte stream from the request parser, together with the header key length. It packs the bytes into 12-byte little-endian blocks (k0/k1/k2) carrying the total length and the remaining-bytes count per block. It also polices length consistency and drops keys that cannot be hashed.

---
 rtl/memcache_key_packer.sv | 189 ++++++++++++++++++
 tb/tb_memcache_key_packer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memcache_key_packer.sv
// memcache_key_packer
//
// Packs a memcache key, arriving one byte per beat from the request parser,
// into 12-byte little-endian blocks (k0/k1/k2) for the lookup3 hash pipeline.
// Each block carries the declared key length and the number of key bytes
// remaining from the block's first byte. Keys whose declared length is 0 or
// above MAXLEN are dropped. Keys whose byte count disagrees with the declared
// length are flagged with an err pulse.
//
// State table:
//   IDLE  | waiting for the first byte of a key
//   FILL  | accumulating key bytes into the current block
//   DRAIN | discarding bytes of a rejected or overlong key up to in_last
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   in_data/in_len      key byte; declared key length (sampled on first byte)
//   in_valid/in_last    byte valid; final byte of key
//   in_ready            byte accepted when in_valid && in_ready
//   out_k0/k1/k2        block words, byte 0 at out_k0[7:0]
//   out_len/out_rem     declared length; bytes remaining from block start
//   out_first/out_last  first / final block of key
//   out_valid/out_ready block handshake
//   err                 one-cycle pulse on a length violation
module memcache_key_packer #(
    parameter int MAXLEN = 250
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_len,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_k0,
    output logic [31:0] out_k1,
    output logic [31:0] out_k2,
    output logic [7:0]  out_len,
    output logic [7:0]  out_rem,
    output logic        out_first,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err
);

    localparam logic [7:0] MAXLEN_B = 8'(MAXLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nx;

    logic [95:0] acc, acc_nx;
    logic [3:0]  idx;
    logic [7:0]  cnt, len, rem;
    logic        first;

    logic        take;
    logic        store;
    logic        err_nx;
    logic        from_idle;
    logic [3:0]  pos;
    logic [7:0]  cnt_nx, len_eff, rem_eff;
    logic        first_eff;
    logic        len_hit;
    logic        blk_close;
    logic        blk_last;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        store     = 1'b0;
        err_nx    = 1'b0;

        // DRAIN never stalls: discarded bytes do not need the output register.
        in_ready  = (state == DRAIN) || !out_valid || out_ready;
        take      = in_valid && in_ready;

        // A first byte starts from a fresh block context taken from the header.
        from_idle = (state == IDLE);
        pos       = from_idle ? 4'd0 : idx;
        cnt_nx    = from_idle ? 8'd1 : cnt + 8'd1;
        len_eff   = from_idle ? in_len : len;
        rem_eff   = from_idle ? in_len : rem;
        first_eff = from_idle ? 1'b1 : first;

        acc_nx = from_idle ? 96'd0 : acc;
        for (int i = 0; i < 12; i++) begin
            if (pos == i[3:0]) acc_nx[i*8 +: 8] = in_data;
        end

        len_hit   = (cnt_nx == len_eff);
        blk_close = 1'b0;
        blk_last  = 1'b0;

        case (state)
            IDLE: begin
                if (take) begin
                    if (in_len == 8'd0 || in_len > MAXLEN_B) begin
                        err_nx = 1'b1;
                        if (!in_last) state_nx = DRAIN;
                    end else begin
                        store = 1'b1;
                    end
                end
            end
            FILL: begin
                if (take) store = 1'b1;
            end
            DRAIN: begin
                if (take && in_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (store) begin
            blk_close = (pos == 4'd11) || len_hit || in_last;
            blk_last  = len_hit || in_last;
            if (len_hit) begin
                // Declared length reached; any further bytes are an overrun.
                state_nx = in_last ? IDLE : DRAIN;
                err_nx   = !in_last;
            end else if (in_last) begin
                state_nx = IDLE;
                err_nx   = 1'b1;
            end else begin
                state_nx = FILL;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc       <= '0;
            idx       <= '0;
            cnt       <= '0;
            len       <= '0;
            rem       <= '0;
            first     <= 1'b0;
            out_k0    <= '0;
            out_k1    <= '0;
            out_k2    <= '0;
            out_len   <= '0;
            out_rem   <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= err_nx;

            if (out_valid && out_ready) out_valid <= 1'b0;

            if (store) begin
                cnt <= cnt_nx;
                len <= len_eff;
                if (blk_close) begin
                    out_k0    <= acc_nx[31:0];
                    out_k1    <= acc_nx[63:32];
                    out_k2    <= acc_nx[95:64];
                    out_len   <= len_eff;
                    out_rem   <= rem_eff;
                    out_first <= first_eff;
                    out_last  <= blk_last;
                    out_valid <= 1'b1;
                    // rem may wrap after the final block; it is never read then.
                    rem       <= rem_eff - 8'd12;
                    first     <= 1'b0;
                    idx       <= 4'd0;
                    acc       <= '0;
                end else begin
                    acc   <= acc_nx;
                    idx   <= pos + 4'd1;
                    rem   <= rem_eff;
                    first <= first_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_memcache_key_packer.sv
// Self-checking bench for memcache_key_packer. A per-key model turns each key
// (bytes sent, declared length) into the list of blocks it must produce; a
// compare process checks every presented block against that list on every
// cycle it is valid, and directed tests pin the model with literal values.
module tb_memcache_key_packer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  in_data = '0;
    logic [7:0]  in_len = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] out_k0, out_k1, out_k2;
    logic [7:0]  out_len, out_rem;
    logic        out_first, out_last, out_valid;
    logic        out_ready = 1'b1;
    logic        err;

    memcache_key_packer #(.MAXLEN(250)) dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready),
        .out_k0(out_k0), .out_k1(out_k1), .out_k2(out_k2),
        .out_len(out_len), .out_rem(out_rem),
        .out_first(out_first), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] k0, k1, k2;
        logic [7:0]  len, rem;
        logic        first, last, err;
    } blk_t;

    blk_t        exp_q[$];
    blk_t        cur, lb, fb;
    logic        have_cur = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_cons = 1'b0;
    logic        fresh;
    logic [7:0]  key_buf [256];

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;
    int exp_err_nb = 0;
    int blk_count = 0;
    int stalls = 0;
    int cyc = 0;
    int c0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Expected blocks for a key of n bytes sent with declared length l.
    task automatic model_key(input int n, input int l);
        int used, nblk;
        logic [95:0] w;
        blk_t b;
        if (l == 0 || l > 250) begin
            exp_err_nb++;
            return;
        end
        used = (n < l) ? n : l;
        nblk = (used + 11) / 12;
        for (int bi = 0; bi < nblk; bi++) begin
            w = '0;
            for (int j = 0; j < 12; j++)
                if (bi * 12 + j < used) w[j*8 +: 8] = key_buf[bi * 12 + j];
            b.k0    = w[31:0];
            b.k1    = w[63:32];
            b.k2    = w[95:64];
            b.len   = 8'(l);
            b.rem   = 8'(l - 12 * bi);
            b.first = (bi == 0);
            b.last  = (bi == nblk - 1);
            b.err   = (bi == nblk - 1) && (n != l);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [7:0] l, input logic last);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        in_last  = last;
        forever begin
            @(negedge CLK);
            if (in_ready) break;
            stalls++;
            g++;
            if (g > 200) begin
                flag("in_ready_timeout");
                break;
            end
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_key(input int n, input int l);
        for (int i = 0; i < n; i++) send_byte(key_buf[i], 8'(l), (i == n - 1));
    endtask

    task automatic settle(input string tag);
        repeat (4) @(posedge CLK);
        #1;
        chk({tag, "_all_blocks_seen"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_err_no_block"}, 32'(err_seen), 32'(exp_err_nb));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
        chk({tag, "_k0"},    out_k0, 32'd0);
        chk({tag, "_k1"},    out_k1, 32'd0);
        chk({tag, "_k2"},    out_k2, 32'd0);
        chk({tag, "_len"},   32'(out_len), 32'd0);
        chk({tag, "_rem"},   32'(out_rem), 32'd0);
        chk({tag, "_first"}, 32'(out_first), 32'd0);
        chk({tag, "_last"},  32'(out_last), 32'd0);
    endtask

    task automatic load_abc();
        key_buf[0] = 8'h61;
        key_buf[1] = 8'h62;
        key_buf[2] = 8'h63;
    endtask

    task automatic check_abc(input string tag);
        chk({tag, "_k0"},    lb.k0, 32'h00636261);
        chk({tag, "_k1"},    lb.k1, 32'h0);
        chk({tag, "_k2"},    lb.k2, 32'h0);
        chk({tag, "_rem"},   32'(lb.rem), 32'd3);
        chk({tag, "_first"}, 32'(lb.first), 32'd1);
        chk({tag, "_last"},  32'(lb.last), 32'd1);
        chk({tag, "_err"},   32'(lb.err), 32'd0);
    endtask

    // Compare process: every valid cycle is checked against the expected block.
    always @(negedge CLK) begin
        if (RST) begin
            have_cur   = 1'b0;
            prev_valid = 1'b0;
            prev_cons  = 1'b0;
        end else begin
            fresh = !prev_valid || prev_cons;
            if (out_valid && fresh) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_block");
                    have_cur = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    blk_count++;
                    chk("blk_err", 32'(err), 32'(cur.err));
                end
            end else if (err) begin
                if (out_valid) flag("err_not_aligned");
                else err_seen++;
            end
            if (out_valid && have_cur) begin
                chk("blk_k0",    out_k0, cur.k0);
                chk("blk_k1",    out_k1, cur.k1);
                chk("blk_k2",    out_k2, cur.k2);
                chk("blk_len",   32'(out_len), 32'(cur.len));
                chk("blk_rem",   32'(out_rem), 32'(cur.rem));
                chk("blk_first", 32'(out_first), 32'(cur.first));
                chk("blk_last",  32'(out_last), 32'(cur.last));
            end
            if (out_valid && out_ready) begin
                lb.k0 = out_k0; lb.k1 = out_k1; lb.k2 = out_k2;
                lb.len = out_len; lb.rem = out_rem;
                lb.first = out_first; lb.last = out_last;
                lb.err = fresh ? err : 1'b0;
                if (out_first) fb = lb;
            end
            prev_valid = out_valid;
            prev_cons  = out_valid && out_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_vals("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // "abc", one block, out_valid one cycle after the final byte
        load_abc();
        model_key(3, 3);
        send_key(3, 3);
        chk("abc_latency", 32'(out_valid), 32'd1);
        settle("abc");
        check_abc("abc");

        // exactly one full block
        for (int i = 0; i < 12; i++) key_buf[i] = 8'(i + 1);
        model_key(12, 12);
        send_key(12, 12);
        settle("k12");
        chk("k12_k0", lb.k0, 32'h04030201);
        chk("k12_k1", lb.k1, 32'h08070605);
        chk("k12_k2", lb.k2, 32'h0C0B0A09);
        chk("k12_rem", 32'(lb.rem), 32'd12);
        chk("k12_last", 32'(lb.last), 32'd1);

        // 13 bytes, first block held for 5 cycles
        for (int i = 0; i < 13; i++) key_buf[i] = 8'(i + 1);
        model_key(13, 13);
        out_ready = 1'b0;
        fork
            send_key(13, 13);
            begin
                int g;
                g = 0;
                while (!out_valid && g < 100) begin
                    @(negedge CLK);
                    g++;
                end
                chk("hold_valid_seen", 32'(out_valid), 32'd1);
                repeat (5) begin
                    @(negedge CLK);
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                    chk("hold_valid", 32'(out_valid), 32'd1);
                end
                @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        settle("k13");
        chk("k13_b1_rem", 32'(fb.rem), 32'd13);
        chk("k13_b1_last", 32'(fb.last), 32'd0);
        chk("k13_b2_k0", lb.k0, 32'h0000000D);
        chk("k13_b2_rem", 32'(lb.rem), 32'd1);
        chk("k13_b2_last", 32'(lb.last), 32'd1);

        // 250-byte key streamed back to back
        for (int i = 0; i < 250; i++) key_buf[i] = 8'(i * 7 + 3);
        model_key(250, 250);
        blk_count = 0;
        stalls = 0;
        c0 = cyc;
        send_key(250, 250);
        chk("stream_cycles", 32'(cyc - c0), 32'd250);
        chk("stream_stalls", 32'(stalls), 32'd0);
        settle("k250");
        chk("k250_blocks", 32'(blk_count), 32'd21);
        chk("k250_last_rem", 32'(lb.rem), 32'd10);
        chk("k250_last_last", 32'(lb.last), 32'd1);

        // illegal declared lengths: err only, rest drained
        for (int i = 0; i < 4; i++) key_buf[i] = 8'(8'hA0 + i);
        blk_count = 0;
        model_key(4, 251);
        send_key(4, 251);
        settle("len251");
        model_key(3, 0);
        send_key(3, 0);
        settle("len0");
        model_key(1, 251);
        send_key(1, 251);
        settle("len251_single");
        chk("badlen_no_blocks", 32'(blk_count), 32'd0);
        chk("badlen_err_count", 32'(err_seen), 32'd3);

        // short key: declared 5, last on byte 3
        for (int i = 0; i < 3; i++) key_buf[i] = 8'(8'h10 + i);
        model_key(3, 5);
        send_key(3, 5);
        settle("short");
        chk("short_k0", lb.k0, 32'h00121110);
        chk("short_rem", 32'(lb.rem), 32'd5);
        chk("short_last", 32'(lb.last), 32'd1);
        chk("short_err", 32'(lb.err), 32'd1);

        // overlong key: declared 2, four bytes sent
        for (int i = 0; i < 4; i++) key_buf[i] = 8'(8'h20 + i);
        model_key(4, 2);
        send_key(4, 2);
        settle("long");
        chk("long_k0", lb.k0, 32'h00002120);
        chk("long_rem", 32'(lb.rem), 32'd2);
        chk("long_last", 32'(lb.last), 32'd1);
        chk("long_err", 32'(lb.err), 32'd1);

        // reset in the middle of a 20-byte key
        for (int i = 0; i < 7; i++) key_buf[i] = 8'(8'h40 + i);
        for (int i = 0; i < 7; i++) send_byte(key_buf[i], 8'd20, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_vals("midkey_reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        load_abc();
        model_key(3, 3);
        send_key(3, 3);
        settle("after_reset");
        check_abc("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
